// File: rtl/decoder_pkg.sv
// Shared CPU definitions for the decoder slice: RV32I 5-bit opcodes (instr[6:2]),
// ALUOP encodings common with the ALU, and the bundle of registered decode fields.
package decoder_pkg;

    // cpu definitions: major opcodes taken from instr[6:2]
    localparam logic [4:0] OPCODE_LOAD     = 5'b00000;
    localparam logic [4:0] OPCODE_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPCODE_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC    = 5'b00101;
    localparam logic [4:0] OPCODE_STORE    = 5'b01000;
    localparam logic [4:0] OPCODE_OP       = 5'b01100;
    localparam logic [4:0] OPCODE_LUI      = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH   = 5'b11000;
    localparam logic [4:0] OPCODE_JALR     = 5'b11001;
    localparam logic [4:0] OPCODE_JAL      = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM   = 5'b11100;

    // aludefs: ADD must stay at 0 so a reset decoder reads as ADD
    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_SLL  = 4'd2;
    localparam logic [3:0] ALUOP_SLT  = 4'd3;
    localparam logic [3:0] ALUOP_SLTU = 4'd4;
    localparam logic [3:0] ALUOP_XOR  = 4'd5;
    localparam logic [3:0] ALUOP_SRL  = 4'd6;
    localparam logic [3:0] ALUOP_SRA  = 4'd7;
    localparam logic [3:0] ALUOP_OR   = 4'd8;
    localparam logic [3:0] ALUOP_AND  = 4'd9;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  opcode;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [3:0]  aluop;
        logic        s2imm;
    } dec_fields_t;

endpackage

// File: rtl/decoder_immgen.sv
// Combinational RV32I immediate generator: picks I/S/B/U/J format from the opcode
// and sign-extends to 32 bits; opcodes without an immediate yield 0.
module decoder_immgen
    import decoder_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [4:0] opcode;
    assign opcode = instr[6:2];

    always_comb begin
        imm = 32'd0;
        case (opcode)
            OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPCODE_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPCODE_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPCODE_LUI, OPCODE_AUIPC:
                imm = {instr[31:12], 12'd0};
            OPCODE_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decoder.sv
// Registered RV32I field decoder (latency 1, fields held while I_en is low).
// Define DECODER_ILLEGAL_CHECK_EN to build the illegal-instruction checker.
module decoder
    import decoder_pkg::*;
#(
    parameter bit ZERO_RD_ON_NOWRITE = 1'b1
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_en,
    input  logic [31:0] I_instr,
    output logic        O_valid,
    output logic [4:0]  O_rs1,
    output logic [4:0]  O_rs2,
    output logic [4:0]  O_rd,
    output logic [4:0]  O_opcode,
    output logic [2:0]  O_funct3,
    output logic [31:0] O_imm,
    output logic [3:0]  O_aluop,
    output logic        O_s2imm,
    output logic        O_illegal
);

    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    dec_fields_t dec;

    assign opcode = I_instr[6:2];
    assign funct3 = I_instr[14:12];
    assign funct7 = I_instr[31:25];

    decoder_immgen u_immgen (
        .instr (I_instr),
        .imm   (imm)
    );

    always_comb begin
        dec        = '0;
        dec.rs1    = I_instr[19:15];
        dec.rs2    = I_instr[24:20];
        dec.rd     = I_instr[11:7];
        dec.opcode = opcode;
        dec.funct3 = funct3;
        dec.imm    = imm;
        dec.aluop  = ALUOP_ADD;
        dec.s2imm  = 1'b0;

        if (ZERO_RD_ON_NOWRITE && (opcode == OPCODE_STORE || opcode == OPCODE_BRANCH))
            dec.rd = 5'd0;

        case (opcode)
            OPCODE_OP, OPCODE_OP_IMM: begin
                case (funct3)
                    3'b000:  dec.aluop = (opcode == OPCODE_OP && I_instr[30]) ? ALUOP_SUB : ALUOP_ADD;
                    3'b001:  dec.aluop = ALUOP_SLL;
                    3'b010:  dec.aluop = ALUOP_SLT;
                    3'b011:  dec.aluop = ALUOP_SLTU;
                    3'b100:  dec.aluop = ALUOP_XOR;
                    3'b101:  dec.aluop = I_instr[30] ? ALUOP_SRA : ALUOP_SRL;
                    3'b110:  dec.aluop = ALUOP_OR;
                    default: dec.aluop = ALUOP_AND;
                endcase
            end
            // compare-style ops so the ALU flags resolve the branch condition
            OPCODE_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   dec.aluop = ALUOP_SLT;
                    2'b11:   dec.aluop = ALUOP_SLTU;
                    default: dec.aluop = ALUOP_SUB;
                endcase
            end
            default: dec.aluop = ALUOP_ADD;
        endcase

        case (opcode)
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_STORE,
            OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC: dec.s2imm = 1'b1;
            default:                               dec.s2imm = 1'b0;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            O_valid  <= 1'b0;
            O_rs1    <= 5'd0;
            O_rs2    <= 5'd0;
            O_rd     <= 5'd0;
            O_opcode <= 5'd0;
            O_funct3 <= 3'd0;
            O_imm    <= 32'd0;
            O_aluop  <= ALUOP_ADD;
            O_s2imm  <= 1'b0;
        end else begin
            O_valid <= I_en;
            if (I_en) begin
                O_rs1    <= dec.rs1;
                O_rs2    <= dec.rs2;
                O_rd     <= dec.rd;
                O_opcode <= dec.opcode;
                O_funct3 <= dec.funct3;
                O_imm    <= dec.imm;
                O_aluop  <= dec.aluop;
                O_s2imm  <= dec.s2imm;
            end
        end
    end

`ifdef DECODER_ILLEGAL_CHECK_EN
    logic illegal_d;

    always_comb begin
        illegal_d = 1'b0;
        if (I_instr[1:0] != 2'b11)
            illegal_d = 1'b1;
        case (opcode)
            OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_AUIPC, OPCODE_STORE,
            OPCODE_LUI, OPCODE_JALR, OPCODE_JAL, OPCODE_SYSTEM: ;
            OPCODE_OP: begin
                if (funct7 == 7'h20) begin
                    if (funct3 != 3'b000 && funct3 != 3'b101)
                        illegal_d = 1'b1;
                end else if (funct7 != 7'h00) begin
                    illegal_d = 1'b1;
                end
            end
            // shift amounts above 31 land in funct7 and are rejected here too
            OPCODE_OP_IMM: begin
                if (funct3 == 3'b001 && funct7 != 7'h00)
                    illegal_d = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
                    illegal_d = 1'b1;
            end
            OPCODE_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    illegal_d = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset)
            O_illegal <= 1'b0;
        else if (I_en)
            O_illegal <= illegal_d;
    end
`else
    logic unused_low_bits;
    assign unused_low_bits = ^{I_instr[1:0], funct7};
    assign O_illegal = 1'b0;
`endif

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 SHALL have parameter ZERO_RD_ON_NOWRITE, default 1: when 1, O_rd is forced to 0 for STORE and BRANCH opcodes.
REQ-002 SHALL have port I_clk  input  1  clock.
REQ-003 SHALL have port I_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port I_en  input  1  decode enable; I_instr is sampled on a rising I_clk edge when high.
REQ-005 SHALL have port I_instr  input  32  RV32I instruction word.
REQ-006 SHALL have port O_valid  output  1  decoded fields updated this cycle.
REQ-007 SHALL have ports O_rs1, O_rs2, O_rd  output  5 each  register indices taken from instr[19:15], [24:20] and [11:7].
REQ-008 SHALL have port O_opcode  output  5  instr[6:2].
REQ-009 SHALL have port O_funct3  output  3  instr[14:12].
REQ-010 SHALL have port O_imm  output  32  sign-extended immediate.
REQ-011 SHALL have port O_aluop  output  4  ALU operation, using the shared ALUOP encoding.
REQ-012 SHALL have port O_s2imm  output  1  ALU operand 2 is O_imm rather than rs2.
REQ-013 SHALL have port O_illegal  output  1  illegal-instruction flag.

Function
REQ-014 SHALL register all outputs; when I_en is sampled high at edge N, the outputs reflect I_instr after edge N (latency 1).
REQ-015 SHALL hold all field outputs unchanged while I_en is low.
REQ-016 SHALL drive O_valid 1 for exactly the cycle after each edge that samples I_en high, and 0 otherwise; back-to-back enables keep O_valid high continuously.
REQ-017 SHALL select the immediate format from the opcode:
- I: LOAD, OP-IMM, JALR
- S: STORE
- B: BRANCH
- U: LUI, AUIPC (low 12 bits zero)
- J: JAL
- all other opcodes: 0.
REQ-018 SHALL set O_aluop for OP and OP-IMM from funct3:
- 000: ADD; SUB only for OP with instr[30]=1
- 001: SLL
- 010: SLT
- 011: SLTU
- 100: XOR
- 101: SRL, or SRA when instr[30]=1
- 110: OR
- 111: AND
REQ-019 SHALL set O_aluop for BRANCH to SUB for funct3 00x, SLT for 10x and SLTU for 11x, so the ALU's O_eq, O_lt and O_ltu flags resolve the branch.
REQ-020 SHALL set O_aluop to ADD for all other opcodes.
REQ-021 SHALL set O_s2imm to 1 for OP-IMM, LOAD, STORE, JALR, LUI and AUIPC, and to 0 otherwise.
REQ-022 SHALL treat OP-IMM shift amounts as O_imm[4:0], with O_imm[31:5] taken from the I-format sign extension.

Reset
REQ-023 SHALL, when I_reset is sampled high, clear every output to 0 (O_aluop = ADD encoding 0); I_reset takes priority over I_en.
REQ-024 SHALL discard an instruction presented with I_en high in the same cycle as I_reset (O_valid 0 on the following cycle).

Configuration
REQ-025 SHALL, with DECODER_ILLEGAL_CHECK_EN defined, set O_illegal (same timing as the other fields) for any of:
- instr[1:0] != 11
- an opcode outside {LOAD, MISC-MEM, OP-IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM}
- OP with funct7 not in {0x00, 0x20}, or funct7 0x20 with funct3 not in {000, 101}
- OP-IMM shift with an invalid funct7
- BRANCH with funct3 010 or 011
REQ-026 SHALL, without DECODER_ILLEGAL_CHECK_EN, tie O_illegal to constant 0 and instantiate no check logic.

Structure
REQ-027 SHALL take ALUOP_* codes from the shared ALU definitions header (aludefs); 5-bit opcode constants (OPCODE_LOAD ... OPCODE_SYSTEM) SHALL be added to a shared cpu definitions header.
REQ-028 SHALL keep immediate generation in one sub-module, immgen (combinational, instr in, 32-bit imm out), instantiated once.

Verification
REQ-029 SHALL cover: I_en=1, I_instr=0x002081B3 (add x3,x1,x2) -> next cycle rs1=1, rs2=2, rd=3, aluop=ADD, s2imm=0, O_valid=1.
REQ-030 SHALL cover: 0x407302B3 (sub x5,x6,x7) -> aluop=SUB, rd=5; 0x40735293 (srai x5,x6,7) -> aluop=SRA, imm[4:0]=7, s2imm=1.
REQ-031 SHALL cover: 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, aluop=ADD, s2imm=1.
REQ-032 SHALL cover: 0xFE20CEE3 (blt x1,x2,-4) -> imm=0xFFFFFFFC, aluop=SLT, rd=0 (ZERO_RD_ON_NOWRITE=1).
REQ-033 SHALL cover: 0x00000000 -> O_illegal=1 with DECODER_ILLEGAL_CHECK_EN, and 0 without it.
REQ-034 SHALL cover: decode add, drop I_en for 3 cycles -> fields held and O_valid=0; assert I_reset with I_en=1 -> all outputs 0 on the next cycle.
